moving_avg_core: RTL

Parametrised successor to the fixed 16-tap ADC moving sum. It keeps a circular window of 2^LOG2_N signed samples and maintains a running accumulator (add newest, subtract oldest). It emits the arithmetic window mean on an AXI-Stream master with backpressure. It sits between the ADC capture interface and the floating-point conversion stage.

---
 rtl/moving_avg_core.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/moving_avg_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : moving_avg_core
// Purpose  : Windowed moving average of 2^LOG2_N signed ADC samples, emitted
//            on an AXI-Stream master. Optional MAVG_FILL_GATE_EN holds off
//            tvalid until the window has been completely filled.
// Revision : 1.0 - initial release
// ============================================================================
module moving_avg_core #(
  parameter int DATA_W     = 24,
  parameter int LOG2_N     = 4,
  parameter int OUT_W      = 32,
  parameter int OFFSET_BIN = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_adc_data,
  input  logic              i_adc_valid,
  output logic [OUT_W-1:0]  adc_m_axis_tdata,
  output logic              adc_m_axis_tvalid,
  input  logic              adc_m_axis_tready,
  output logic              o_drop,
  output logic              o_ovr
);

  localparam int N     = 1 << LOG2_N;
  localparam int ACC_W = DATA_W + LOG2_N;
  localparam logic [LOG2_N:0] FILL_MAX = (LOG2_N+1)'(N);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_UPDATE = 3'd2,
    ST_OUT    = 3'd3,
    ST_CLEAR  = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [DATA_W-1:0]        sbuf_q [N];
  logic [DATA_W-1:0]        sbuf_d [N];
  logic [LOG2_N-1:0]        wr_ptr_q, wr_ptr_d;
  logic [LOG2_N-1:0]        clr_idx_q, clr_idx_d;
  logic [LOG2_N:0]          fill_q, fill_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        samp_q, samp_d;
  logic [DATA_W-1:0]        old_q, old_d;
  logic signed [DATA_W-1:0] res_q, res_d;
  logic                     clr_pend_q, clr_pend_d;
  logic [OUT_W-1:0]         tdata_q, tdata_d;
  logic                     tvalid_q, tvalid_d;
  logic                     drop_q, drop_d;
  logic                     ovr_q, ovr_d;

  logic [DATA_W-1:0]        samp_conv;
  logic                     fill_gate;

  generate
    if (OFFSET_BIN != 0) begin : g_offset_bin
      assign samp_conv = {~i_adc_data[DATA_W-1], i_adc_data[DATA_W-2:0]};
    end else begin : g_twos_comp
      assign samp_conv = i_adc_data;
    end
  endgenerate

`ifdef MAVG_FILL_GATE_EN
  assign fill_gate = (fill_q == FILL_MAX);
`else
  assign fill_gate = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    sbuf_d     = sbuf_q;
    wr_ptr_d   = wr_ptr_q;
    clr_idx_d  = clr_idx_q;
    fill_d     = fill_q;
    acc_d      = acc_q;
    samp_d     = samp_q;
    old_d      = old_q;
    res_d      = res_q;
    clr_pend_d = clr_pend_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    drop_d     = drop_q;
    ovr_d      = ovr_q;

    if (tvalid_q && adc_m_axis_tready)
      tvalid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clr_pend_q || i_clr) begin
          state_d    = ST_CLEAR;
          acc_d      = '0;
          fill_d     = '0;
          wr_ptr_d   = '0;
          clr_idx_d  = '0;
          drop_d     = 1'b0;
          ovr_d      = 1'b0;
          tvalid_d   = 1'b0;
          clr_pend_d = 1'b0;
        end else if (i_adc_valid) begin
          samp_d  = samp_conv;
          old_d   = sbuf_q[wr_ptr_q];
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sbuf_d[wr_ptr_q] = samp_q;
        // Window sum cannot overflow: ACC_W holds 2^LOG2_N full-scale samples.
        acc_d    = acc_q + ACC_W'($signed(samp_q)) - ACC_W'($signed(old_q));
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (fill_q != FILL_MAX)
          fill_d = fill_q + 1'b1;
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        res_d   = DATA_W'(acc_q >>> LOG2_N);
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (fill_gate) begin
          if (tvalid_q && !adc_m_axis_tready)
            ovr_d = 1'b1;
          tdata_d  = OUT_W'(res_q);
          tvalid_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        sbuf_d[clr_idx_q] = '0;
        clr_idx_d         = clr_idx_q + 1'b1;
        if (clr_idx_q == '1)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Busy states drop samples and defer clears; CLEAR drops silently.
    if (state_q inside {ST_LOAD, ST_UPDATE, ST_OUT}) begin
      if (i_adc_valid)
        drop_d = 1'b1;
    end
    if (state_q inside {ST_LOAD, ST_UPDATE, ST_OUT, ST_CLEAR}) begin
      if (i_clr)
        clr_pend_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < N; i++)
        sbuf_q[i] <= '0;
      wr_ptr_q   <= '0;
      clr_idx_q  <= '0;
      fill_q     <= '0;
      acc_q      <= '0;
      samp_q     <= '0;
      old_q      <= '0;
      res_q      <= '0;
      clr_pend_q <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      drop_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sbuf_q     <= sbuf_d;
      wr_ptr_q   <= wr_ptr_d;
      clr_idx_q  <= clr_idx_d;
      fill_q     <= fill_d;
      acc_q      <= acc_d;
      samp_q     <= samp_d;
      old_q      <= old_d;
      res_q      <= res_d;
      clr_pend_q <= clr_pend_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      drop_q     <= drop_d;
      ovr_q      <= ovr_d;
    end
  end

  assign adc_m_axis_tdata  = tdata_q;
  assign adc_m_axis_tvalid = tvalid_q;
  assign o_drop            = drop_q;
  assign o_ovr             = ovr_q;

endmodule
`default_nettype wire
